// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one N-bit ALU between NUM_REQ requesters, with a
// multi-cycle MUL and a one-entry response slot. Optional: ALU_ARB_ILLEGAL_OP_EN adds resp_illegal.
module alu_arbiter #(
    parameter int unsigned N          = 32,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MUL_CYCLES = 3,
    localparam int unsigned IdW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_opcode,
    input  logic [N*NUM_REQ-1:0] req_a,
    input  logic [N*NUM_REQ-1:0] req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IdW-1:0]       resp_id,
    output logic [N-1:0]         resp_data,
    output logic                 resp_zero
`ifdef ALU_ARB_ILLEGAL_OP_EN
    ,
    output logic                 resp_illegal
`endif
);

    localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [3:0] OpAnd = 4'b0001;
    localparam logic [3:0] OpOr  = 4'b0010;
    localparam logic [3:0] OpSll = 4'b0011;
    localparam logic [3:0] OpAdd = 4'b0100;
    localparam logic [3:0] OpXor = 4'b0111;
    localparam logic [3:0] OpSub = 4'b1001;
    localparam logic [3:0] OpSrl = 4'b1010;
    localparam logic [3:0] OpSlt = 4'b1100;
    localparam logic [3:0] OpMul = 4'b1110;

    typedef enum logic [1:0] {
        StIdle,
        StMulWait,
        StResp
    } state_t;

    state_t          r_state;
    logic [IdW-1:0]  r_rr_ptr;
    logic [CntW-1:0] r_mul_cnt;
    logic [N-1:0]    r_op_a;
    logic [N-1:0]    r_op_b;
    logic [IdW-1:0]  r_op_id;
    logic            r_resp_valid;
    logic [IdW-1:0]  r_resp_id;
    logic [N-1:0]    r_resp_data;
    logic            r_resp_zero;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic            r_resp_illegal;
    logic            w_sel_legal;
`endif

    logic               w_window;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_gnt_any;
    logic [IdW-1:0]     w_gnt_idx;
    logic [IdW-1:0]     w_ptr_next;
    logic [3:0]         w_sel_op;
    logic [N-1:0]       w_sel_a;
    logic [N-1:0]       w_sel_b;
    logic               w_sel_mul;
    logic [N-1:0]       w_alu_res;
    logic [N-1:0]       w_mul_res;

    function automatic logic [N-1:0] alu_calc(input logic [3:0] op, input logic [N-1:0] a,
                                              input logic [N-1:0] b);
        logic [N-1:0] res;
        res = '0;
        case (op)
            OpAnd:   res = a & b;
            OpOr:    res = a | b;
            OpXor:   res = a ^ b;
            OpAdd:   res = a + b;
            OpSub:   res = a - b;
            OpSlt:   res[0] = (a < b);
            OpSll:   res = (b >= N) ? '0 : (a << b);
            OpSrl:   res = (b >= N) ? '0 : (a >> b);
            OpMul:   res = a * b;
            default: res = '0;
        endcase
        return res;
    endfunction

`ifdef ALU_ARB_ILLEGAL_OP_EN
    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OpAnd, OpOr, OpXor, OpAdd, OpSub, OpSlt, OpSll, OpSrl, OpMul: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
`endif

    // Grants only while the slot is free or being drained this cycle.
    assign w_window = !reset &&
                      ((r_state == StIdle) || ((r_state == StResp) && resp_ready));

    always_comb begin : p_arb
        int v_idx;
        v_idx     = 0;
        w_grant   = '0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_sel_op  = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        if (w_window) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                v_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
                if (!w_gnt_any && req_valid[v_idx]) begin
                    w_gnt_any      = 1'b1;
                    w_gnt_idx      = IdW'(v_idx);
                    w_grant[v_idx] = 1'b1;
                    w_sel_op       = req_opcode[4*v_idx +: 4];
                    w_sel_a        = req_a[N*v_idx +: N];
                    w_sel_b        = req_b[N*v_idx +: N];
                end
            end
        end
    end

    assign w_ptr_next = (w_gnt_idx == IdW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_sel_mul  = (w_sel_op == OpMul);
    assign w_alu_res  = alu_calc(w_sel_op, w_sel_a, w_sel_b);
    assign w_mul_res  = r_op_a * r_op_b;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign w_sel_legal = op_legal(w_sel_op);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= StIdle;
            r_rr_ptr       <= '0;
            r_mul_cnt      <= '0;
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_op_id        <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_id      <= '0;
            r_resp_data    <= '0;
            r_resp_zero    <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            r_resp_illegal <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle, StResp: begin
                    if (w_gnt_any) begin
                        r_rr_ptr <= w_ptr_next;
                        if (w_sel_mul && (MUL_CYCLES > 1)) begin
                            r_op_a       <= w_sel_a;
                            r_op_b       <= w_sel_b;
                            r_op_id      <= w_gnt_idx;
                            r_mul_cnt    <= CntW'(MUL_CYCLES - 1);
                            r_resp_valid <= 1'b0;
                            r_state      <= StMulWait;
                        end else begin
                            r_resp_valid   <= 1'b1;
                            r_resp_id      <= w_gnt_idx;
                            r_resp_data    <= w_alu_res;
                            r_resp_zero    <= (w_alu_res == '0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
                            r_resp_illegal <= !w_sel_legal;
`endif
                            r_state        <= StResp;
                        end
                    end else if ((r_state == StResp) && resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= StIdle;
                    end
                end
                StMulWait: begin
                    if (r_mul_cnt == CntW'(1)) begin
                        r_mul_cnt      <= '0;
                        r_resp_valid   <= 1'b1;
                        r_resp_id      <= r_op_id;
                        r_resp_data    <= w_mul_res;
                        r_resp_zero    <= (w_mul_res == '0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
                        r_resp_illegal <= 1'b0;
`endif
                        r_state        <= StResp;
                    end else begin
                        r_mul_cnt <= r_mul_cnt - 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign req_ready    = w_grant;
    assign resp_valid   = r_resp_valid;
    assign resp_id      = r_resp_id;
    assign resp_data    = r_resp_data;
    assign resp_zero    = r_resp_zero;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign resp_illegal = r_resp_illegal;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against a transaction-level model.
module tb_alu_arbiter;

    localparam int N  = 32;
    localparam int NR = 4;
    localparam int MC = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [4*NR-1:0] req_opcode;
    logic [N*NR-1:0] req_a;
    logic [N*NR-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [1:0]      resp_id;
    logic [N-1:0]    resp_data;
    logic            resp_zero;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic            resp_illegal;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(
        .N         (N),
        .NUM_REQ   (NR),
        .MUL_CYCLES(MC)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_data   (resp_data),
`ifdef ALU_ARB_ILLEGAL_OP_EN
        .resp_illegal(resp_illegal),
`endif
        .resp_zero   (resp_zero)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus held per requester
    bit [3:0]    s_op[NR];
    bit [31:0]   s_a[NR];
    bit [31:0]   s_b[NR];
    bit [NR-1:0] s_v;
    bit          s_rr;

    // Model: response slot plus a countdown for an outstanding MUL
    int        m_ptr;
    bit        m_sv;
    int        m_sid;
    bit [31:0] m_sdata;
    bit        m_sill;
    int        m_pend;
    int        m_pid;
    bit [31:0] m_pdata;

    int          last_grant;
    bit [NR-1:0] obs_ready;
    bit          obs_valid;
    bit [31:0]   obs_data;
    bit          obs_zero;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] ref_alu(input bit [3:0] op, input bit [31:0] a,
                                          input bit [31:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        case (op)
            4'b0001: return a & b;
            4'b0010: return a | b;
            4'b0111: return a ^ b;
            4'b0100: return a + b;
            4'b1001: return a - b;
            4'b1100: return (a < b) ? 32'd1 : 32'd0;
            4'b0011: return (b >= 32) ? 32'd0 : (a << b);
            4'b1010: return (b >= 32) ? 32'd0 : (a >> b);
            4'b1110: return p[31:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit ref_legal(input bit [3:0] op);
        case (op)
            4'b0001, 4'b0010, 4'b0111, 4'b0100, 4'b1001,
            4'b1100, 4'b0011, 4'b1010, 4'b1110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive();
        req_valid  = s_v;
        resp_ready = s_rr;
        for (int k = 0; k < NR; k++) begin
            req_opcode[4*k +: 4] = s_op[k];
            req_a[N*k +: N]      = s_a[k];
            req_b[N*k +: N]      = s_b[k];
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_sv   = 1'b0;
        m_pend = 0;
    endtask

    // One clock: drive at negedge, compare before posedge, advance model after it.
    task automatic cycle();
        int g;
        bit win;
        bit [NR-1:0] exp_rdy;
        @(negedge clk);
        drive();
        #1;
        win = (!m_sv && m_pend == 0) || (m_sv && s_rr);
        g = -1;
        if (win) begin
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && s_v[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_eq("req_ready", req_ready, exp_rdy);
        check_eq("resp_valid", resp_valid, m_sv);
        if (m_sv) begin
            check_eq("resp_id", resp_id, m_sid);
            check_eq("resp_data", resp_data, m_sdata);
            check_eq("resp_zero", resp_zero, m_sdata == 0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
            check_eq("resp_illegal", resp_illegal, m_sill);
`endif
        end
        last_grant = g;
        obs_ready  = req_ready;
        obs_valid  = resp_valid;
        obs_data   = resp_data;
        obs_zero   = resp_zero;
        @(posedge clk);
        if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) begin
                m_sv    = 1'b1;
                m_sid   = m_pid;
                m_sdata = m_pdata;
                m_sill  = 1'b0;
            end
        end else if (g >= 0) begin
            m_ptr = (g + 1) % NR;
            if (s_op[g] == 4'b1110 && MC > 1) begin
                m_sv    = 1'b0;
                m_pend  = MC - 1;
                m_pid   = g;
                m_pdata = ref_alu(s_op[g], s_a[g], s_b[g]);
            end else begin
                m_sv    = 1'b1;
                m_sid   = g;
                m_sdata = ref_alu(s_op[g], s_a[g], s_b[g]);
                m_sill  = !ref_legal(s_op[g]);
            end
        end else if (m_sv && s_rr) begin
            m_sv = 1'b0;
        end
    endtask

    task automatic set_one(input int id, input bit [3:0] op, input bit [31:0] a,
                           input bit [31:0] b);
        s_v = '0;
        s_v[id] = 1'b1;
        s_op[id] = op;
        s_a[id]  = a;
        s_b[id]  = b;
    endtask

    bit [3:0]  bnd_op[4]  = '{4'b0011, 4'b1100, 4'b0100, 4'b0000};
    bit [31:0] bnd_a[4]   = '{32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234};
    bit [31:0] bnd_b[4]   = '{32'd32, 32'h1, 32'h1, 32'h5678};
    bit [3:0]  rnd_ops[12] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'hC, 4'h3, 4'hA, 4'hE, 4'h7,
                               4'h0, 4'h5, 4'hF};

    initial begin
        int exp_g;
        for (int k = 0; k < NR; k++) begin
            s_op[k] = 4'b0100;
            s_a[k]  = 32'(k * 16);
            s_b[k]  = 32'(k + 1);
        end
        s_v   = '1;
        s_rr  = 1'b1;
        reset = 1'b1;
        drive();
        model_reset();
        #12;
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_valid", resp_valid, 0);
        check_eq("rst_id", resp_id, 0);
        check_eq("rst_data", resp_data, 0);
        check_eq("rst_zero", resp_zero, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Round robin from pointer 0
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("rr_grant", last_grant, i % NR);
        end
        s_v = '0;
        cycle();

        // Single requester 1 ADD
        set_one(1, 4'b0100, 32'h5, 32'h3);
        cycle();
        check_eq("t1_ready", obs_ready, 4'b0010);
        s_v = '0;
        cycle();
        check_eq("t1_data", obs_data, 32'd8);
        check_eq("t1_valid", obs_valid, 1);

        // MUL latency and blocked grants
        set_one(0, 4'b1110, 32'h0001_0000, 32'h0001_0000);
        cycle();
        check_eq("mul_accept", obs_ready, 4'b0001);
        s_v = 4'b1110;
        cycle();
        check_eq("mul_wait_rdy", obs_ready, 0);
        cycle();
        check_eq("mul_wait_vld", obs_valid, 0);
        s_v = '0;
        cycle();
        check_eq("mul_lat", obs_valid, 1);
        check_eq("mul_data", obs_data, 0);
        check_eq("mul_zero", obs_zero, 1);

        // Backpressure with SUB 7-7
        set_one(2, 4'b1001, 32'd7, 32'd7);
        cycle();
        s_v  = '1;
        s_rr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("bp_nogrant", obs_ready, 0);
            check_eq("bp_hold", {obs_valid, obs_zero, obs_data}, {2'b11, 32'd0});
        end
        s_rr = 1'b1;
        cycle();
        check_eq("bp_regrant", obs_ready != 0, 1);
        s_v = '0;
        cycle();
        cycle();

        // Boundary cases, all expected to yield 0
        for (int i = 0; i < 4; i++) begin
            set_one(0, bnd_op[i], bnd_a[i], bnd_b[i]);
            cycle();
            s_v = '0;
            cycle();
            check_eq("bnd_data", obs_data, 0);
            check_eq("bnd_zero", obs_zero, 1);
        end
        cycle();

        // Reset during MUL_WAIT
        set_one(3, 4'b1110, 32'd9, 32'd9);
        cycle();
        s_v = '1;
        cycle();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("mrst_ready", req_ready, 0);
        check_eq("mrst_valid", resp_valid, 0);
        check_eq("mrst_data", resp_data, 0);
        check_eq("mrst_id", resp_id, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        s_v = 4'b1100;
        cycle();
        check_eq("mrst_first", last_grant, 2);
        s_v = '0;
        for (int i = 0; i < 4; i++) cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NR; k++) begin
                s_op[k] = rnd_ops[$urandom_range(0, 11)];
                s_a[k]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                s_b[k]  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            end
            s_v  = NR'($urandom);
            s_rr = ($urandom_range(0, 9) < 7);
            cycle();
        end
        exp_g = 0;
        s_v = '0;
        s_rr = 1'b1;
        for (int i = 0; i < MC + 2; i++) cycle();
        check_eq("drain_valid", obs_valid, exp_g);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one 32-bit ALU datapath between NUM_REQ requesters, such as the decode-issue port, address generation and debug.
- Round-robin arbitration with a valid/ready request handshake.
- MUL is sequenced over a configurable number of cycles.
- One-entry registered response slot with backpressure.
- Sits between the requesting units and the shared ALU and owns all sequencing of it.

Parameters:
N, 32, operand/result width
NUM_REQ, 4, number of requesters (>=2)
MUL_CYCLES, 3, cycles MUL occupies the ALU before its result is captured (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i]
req_opcode  input  4*NUM_REQ  op code, slice i = [4i+3:4i]
req_a  input  N*NUM_REQ  operand A, slice i = [N*i+N-1:N*i]
req_b  input  N*NUM_REQ  operand B, same slicing
resp_valid  output  1  response slot holds a result
resp_ready  input  1  consumer accepts the response
resp_id  output  max(1,$clog2(NUM_REQ))  index of the requester that owns the response
resp_data  output  N  result
resp_zero  output  1  1 when resp_data == 0

Behaviour:
- Op codes:
  - 0001 AND, 0010 OR, 0100 ADD, 1001 SUB.
  - 1100 SLT: unsigned compare, result 1 or 0.
  - 0011 SLL, 1010 SRL: shift amount is the full B value; a shift of N or more yields 0.
  - 1110 MUL: low N bits of the product.
  - 0111 XOR.
  - Any other code yields result 0 and resp_zero=1.
- ADD, SUB and MUL wrap modulo 2^N; no flags beyond zero.
- FSM states: IDLE, MUL_WAIT, RESP.
- Reset values: state IDLE, rr_ptr 0, req_ready 0, resp_valid 0, resp_id 0, resp_data 0, resp_zero 0; MUL counter 0.
- Reset mid-operation discards the in-flight op and produces no response; the async assert takes effect immediately.
- Issue window: state IDLE, or state RESP with resp_ready=1 in the same cycle.
  - Only in the issue window does the arbiter grant.
  - Outside the window req_ready is all-zero.
- Arbitration (combinational within the cycle):
  - Grant the first i with req_valid[i]=1, scanning from rr_ptr upward modulo NUM_REQ.
  - req_ready is one-hot or zero.
  - On an accepted grant to i, rr_ptr <= (i+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
- Non-MUL accept: the result is captured at the same edge; next state RESP; resp_valid=1 the next cycle. Latency is 1 cycle.
- MUL accept, MUL_CYCLES=1: same as non-MUL.
- MUL accept, MUL_CYCLES>1:
  - Operands and id are latched; counter <= MUL_CYCLES-1; next state MUL_WAIT.
  - In MUL_WAIT the counter decrements each cycle; when counter==1 the result is captured and next state is RESP.
  - resp_valid rises MUL_CYCLES cycles after accept.
- RESP:
  - resp_* holds stable while resp_ready=0.
  - resp_ready=1 with a new accept: back-to-back, slot reloaded, resp_valid stays 1.
  - resp_ready=1 with no request: go to IDLE; resp_valid=0 next cycle.
- resp_data/resp_id/resp_zero change only on capture; they are don't-care when resp_valid=0 but hold their last value.
- Requesters may drop req_valid without a grant; there is no obligation on them.
- Throughput: one non-MUL op per cycle under continuous resp_ready.

Optional Feature:
ALU_ARB_ILLEGAL_OP_EN
- Defined:
  - Adds output port resp_illegal (1 bit, reset 0).
  - resp_illegal is set with the response when the captured op code is not in the table; the result is still 0.
  - An illegal op code never enters MUL_WAIT.
- Undefined: the port is absent; illegal op codes silently return 0 with resp_zero=1.

Test Plan:
- Single requester 1: ADD a=0x0000_0005 b=0x0000_0003, resp_ready=1 -> req_ready=0010 on the accept cycle; next cycle resp_valid=1, resp_id=1, resp_data=8, resp_zero=0.
- Round robin: all four requesters valid continuously, resp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one response per cycle, ids in that order.
- MUL with MUL_CYCLES=3: 0x0001_0000*0x0001_0000 -> resp_valid exactly 3 cycles after accept, resp_data=0, resp_zero=1; req_ready=0 during MUL_WAIT.
- Backpressure: SUB 7-7 accepted, resp_ready=0 for 4 cycles -> resp_data=0 and resp_zero=1 held, no new grants; a new grant occurs in the same cycle resp_ready rises.
- Boundaries: SLL 1 by 32 -> 0; SLT 0xFFFF_FFFF<1 -> 0; ADD 0xFFFF_FFFF+1 -> 0 with zero=1; op code 0000 -> 0 (resp_illegal=1 with ALU_ARB_ILLEGAL_OP_EN).
- Reset asserted in MUL_WAIT -> outputs immediately reset values, rr_ptr=0, no response after release; the first post-reset grant goes to the lowest valid index.
